dmem_resp: RTL and testbench
============================

# dmem_resp

Data-side memory responder for the pipelined MIPS core: receives the core's data-port requests (byte address, write data, byte enables, write enable) and returns read data. Contains a 4 KiB byte-enabled RAM plus a small memory-mapped register window (cycle counter, LED register, simulation halt/tohost, status). Replaces the bare data memory at the top level so programs can signal completion and error conditions to the bench.

## Interface
- RAM_AW, 10, word-address width of the RAM (2^RAM_AW words; 10 gives 4 KiB)
- MMIO_BASE, 32'hFFFF_0000, base byte address of the register window (16-byte aligned)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address from the core's MEM stage
- din  in  32  write data
- be  in  4  byte enables, be[i] selects din[8i+7:8i]
- wren  in  1  write request for this cycle
- dout  out  32  read data, combinational from addr
- led  out  32  LED register value
- halt  out  1  sticky halt flag
- err  out  1  sticky access-error flag

## Operation
- Decode: RAM hit when addr[31:RAM_AW+2]==0, word index addr[RAM_AW+1:2]; MMIO hit when addr[31:4]==MMIO_BASE[31:4], register = addr[3:2]; anything else is unmapped. addr[1:0] ignored for decode.
- Registers: 0x0 CYCLE (RO) = cycles since reset release, +1 per clock, wraps 32'hFFFF_FFFF -> 0, frozen while halt=1. 0x4 LED (RW, byte-enabled). 0x8 TOHOST (RW): write stores merged value; if merged value nonzero, halt <= 1. 0xC STATUS (read {30'b0, err, halt}); write with be[0] and din[1]=1 clears err; other bits ignored.
- Writes (wren=1, be!=0, halt=0): RAM/LED/TOHOST bytes updated only on enabled lanes. wren=1 with be=4'b0000 is a no-op, no error.
- Error: err <= 1 on a non-zero-be write to an unmapped address or to CYCLE. Reads never set err (core reads speculatively every cycle). Same-cycle err-set and STATUS clear cannot coincide (different addresses).
- Halt: once set, all further writes (including STATUS clear) are ignored; reads still served. Only reset clears halt.
- Reads: RAM word, register value, or 32'h0 for unmapped. Read-during-write same address returns old data before the edge, new data after.

## Timing
- Reset (rst=0, async): CYCLE, LED, TOHOST = 0; halt=0, err=0; led=0. RAM contents not reset and undefined at power-up. Reset asserted mid-write: register write lost; RAM write on that edge may or may not complete.
- First clock edge with rst=1: CYCLE 0 -> 1.
- Write latency: state visible on dout the cycle after the write edge. halt and err assert on the write edge (registered outputs).
- dout has zero-cycle latency (purely combinational from addr and current state).

## Configuration
- DMEM_RESP_MMIO_EN defined: register window present as above.
- Not defined: no register window; MMIO addresses treated as unmapped (read 0, write sets err); led and halt tied to 0; CYCLE logic removed. RAM and err behaviour unchanged.

## Structure
- Package dmem_resp_pkg: MMIO register offsets (CYCLE, LED, TOHOST, STATUS), STATUS bit positions, region-select enum (RAM, MMIO, UNMAPPED), byte-lane merge function.
- Sub-module dmem_ram: 2^RAM_AW x 32 array, async read, synchronous byte-enabled write; no reset.

## Test plan
- Reset release, idle 10 cycles, read 0xFFFF_0000 -> 10 (±1 per edge count convention documented in bench); led=0, halt=0, err=0.
- Write 0x1122_3344 be=4'hF to 0x10, then 0xAA00_0000 be=4'h8 to 0x10 -> read 0x10 returns 0xAA22_3344.
- Write 0x0000_00FF be=4'h1 to 0xFFFF_0004 -> led=0x0000_00FF next cycle; write be=0 to LED -> unchanged, err=0.
- Write to 0x0001_0000 be=4'hF -> err=1, read returns 0; write 0x2 be=4'h1 to 0xFFFF_000C -> err=0.
- Write 0x1 to 0xFFFF_0008 -> halt=1; CYCLE frozen; subsequent write to 0x10 leaves RAM unchanged; drop rst -> halt=0, CYCLE=0.
- Build without DMEM_RESP_MMIO_EN: write to 0xFFFF_0004 -> err=1, led stays 0, read returns 0.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-side memory responder: register offsets,
// STATUS bit layout, address-region select and the byte-lane merge helper.
package dmem_resp_pkg;

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_LED    = 2'd1;
  localparam logic [1:0] REG_TOHOST = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_HALT_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } region_e;

  // Replace only the byte lanes selected by be; other lanes keep old_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with asynchronous read and synchronous byte-enabled write.
// Contents are never reset.
module dmem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [0:(1<<AW)-1];

  assign rdata = mem_q[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-port responder: byte-enabled RAM plus an optional register window
// (CYCLE/LED/TOHOST/STATUS) enabled by defining DMEM_RESP_MMIO_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  be,
  input  logic        wren,
  output logic [31:0] dout,
  output logic [31:0] led,
  output logic        halt,
  output logic        err
);

  region_e           region;
  logic [1:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;
  logic [31:0]       mmio_rdata;
  logic              wr_act;
  logic              ram_we;
  logic              halt_now;
  logic              err_d, err_q;
  logic              unused_addr;

  // Sub-word offset never affects which location is addressed.
  assign unused_addr = ^addr[1:0];
  assign reg_sel     = addr[3:2];
  assign ram_idx     = addr[RAM_AW+1:2];

  always_comb begin
    region = REGION_UNMAPPED;
    if (addr[31:RAM_AW+2] == '0) begin
      region = REGION_RAM;
    end
`ifdef DMEM_RESP_MMIO_EN
    else if (addr[31:4] == MMIO_BASE[31:4]) begin
      region = REGION_MMIO;
    end
`endif
  end

  // A halted core can no longer change any state, STATUS clear included.
  assign wr_act = wren && (be != 4'b0000) && !halt_now;
  assign ram_we = wr_act && (region == REGION_RAM);

  dmem_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .idx  (ram_idx),
    .wdata(din),
    .rdata(ram_rdata)
  );

`ifdef DMEM_RESP_MMIO_EN
  logic [31:0] cycle_d, cycle_q;
  logic [31:0] led_d, led_q;
  logic [31:0] tohost_d, tohost_q;
  logic        halt_d, halt_q;
  logic        mmio_wr;

  assign mmio_wr = wr_act && (region == REGION_MMIO);

  always_comb begin
    cycle_d  = halt_q ? cycle_q : cycle_q + 32'd1;
    led_d    = led_q;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    if (mmio_wr) begin
      case (reg_sel)
        REG_LED: led_d = merge_bytes(led_q, din, be);
        REG_TOHOST: begin
          tohost_d = merge_bytes(tohost_q, din, be);
          if (tohost_d != 32'h0) halt_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= 32'h0;
      led_q    <= 32'h0;
      tohost_q <= 32'h0;
      halt_q   <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      led_q    <= led_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_sel)
      REG_CYCLE:  mmio_rdata = cycle_q;
      REG_LED:    mmio_rdata = led_q;
      REG_TOHOST: mmio_rdata = tohost_q;
      default: begin
        mmio_rdata[STATUS_HALT_BIT] = halt_q;
        mmio_rdata[STATUS_ERR_BIT]  = err_q;
      end
    endcase
  end

  assign led      = led_q;
  assign halt     = halt_q;
  assign halt_now = halt_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^MMIO_BASE;
  assign mmio_rdata = 32'h0;
  assign led        = 32'h0;
  assign halt       = 1'b0;
  assign halt_now   = 1'b0;
`endif

  // Only real stores flag errors; the core issues speculative reads every cycle.
  always_comb begin
    err_d = err_q;
    if (wr_act) begin
      if ((region == REGION_UNMAPPED) ||
          ((region == REGION_MMIO) && (reg_sel == REG_CYCLE))) begin
        err_d = 1'b1;
      end else if ((region == REGION_MMIO) && (reg_sel == REG_STATUS) &&
                   be[0] && din[STATUS_ERR_BIT]) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  always_comb begin
    dout = 32'h0;
    case (region)
      REGION_RAM:  dout = ram_rdata;
      REGION_MMIO: dout = mmio_rdata;
      default:     dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios followed by random traffic, all
// checked against an address-range reference model. Honours DMEM_RESP_MMIO_EN.
// CYCLE convention: after reset release and N idle edges, CYCLE reads N.
module tb_dmem_resp;

`ifdef DMEM_RESP_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic        wren;
  logic [31:0] dout;
  logic [31:0] led;
  logic        halt;
  logic        err;

  int tests_run;
  int tests_failed;

  // Reference model state.
  logic [31:0] ram_m [0:1023];
  bit          ram_v [0:1023];
  logic [31:0] m_cyc;
  logic [31:0] m_led;
  logic [31:0] m_tohost;
  logic        m_halt;
  logic        m_err;

  dmem_resp #(
    .RAM_AW   (10),
    .MMIO_BASE(32'hFFFF_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .addr(addr),
    .din (din),
    .be  (be),
    .wren(wren),
    .dout(dout),
    .led (led),
    .halt(halt),
    .err (err)
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return MMIO_EN && (a >= 32'hFFFF_0000) && (a < 32'hFFFF_0010);
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    logic [9:0] w;
    w = a[11:2];
    return !is_ram(a) || ram_v[w];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [9:0] w;
    w = a[11:2];
    if (is_ram(a)) return ram_m[w];
    if (is_mmio(a)) begin
      case ((a - 32'hFFFF_0000) / 4)
        0: return m_cyc;
        1: return m_led;
        2: return m_tohost;
        default: return {30'b0, m_err, m_halt};
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_cyc    = 32'h0;
    m_led    = 32'h0;
    m_tohost = 32'h0;
    m_halt   = 1'b0;
    m_err    = 1'b0;
  endtask

  // Effect of one rising edge with rst high.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, input logic w);
    logic [9:0] widx;
    bit         do_wr;
    widx  = a[11:2];
    do_wr = w && (b != 4'b0) && !m_halt;
    if (MMIO_EN && !m_halt) m_cyc = m_cyc + 32'd1;
    if (do_wr) begin
      if (is_ram(a)) begin
        ram_m[widx] = lane_merge(ram_m[widx], d, b);
        if (b == 4'hF) ram_v[widx] = 1'b1;
      end else if (is_mmio(a)) begin
        case ((a - 32'hFFFF_0000) / 4)
          0: m_err = 1'b1;
          1: m_led = lane_merge(m_led, d, b);
          2: begin
            m_tohost = lane_merge(m_tohost, d, b);
            if (m_tohost != 0) m_halt = 1'b1;
          end
          default: if (b[0] && d[1]) m_err = 1'b0;
        endcase
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input logic [31:0] a);
    if (model_known(a)) check("dout", dout, model_read(a));
    check("led", led, m_led);
    check("halt", {31'b0, halt}, {31'b0, m_halt});
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  // Driver: present one request for a full cycle, check before the edge.
  task automatic op(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b, input logic w);
    addr = a;
    din  = d;
    be   = b;
    wren = w;
    @(negedge clk);
    check_outputs(a);
    @(posedge clk);
    model_edge(a, d, b, w);
    #1;
  endtask

  task automatic idle(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) op(a, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    wren = 1'b0;
    addr = 32'hFFFF_0000;
    #1;
    model_reset();
    check_outputs(addr);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    int          k;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 1024; i++) begin
      ram_m[i] = 32'h0;
      ram_v[i] = 1'b0;
    end
    rst  = 1'b0;
    addr = 32'hFFFF_0000;
    din  = 32'h0;
    be   = 4'h0;
    wren = 1'b0;
    model_reset();
    do_reset();

    // Ten idle edges, then CYCLE reads 10 (0 without the register window).
    idle(32'hFFFF_0000, 10);
    check("cycle_after_10", dout, MMIO_EN ? 32'd10 : 32'd0);
    idle(32'hFFFF_0000, 1);

    // Byte-lane merge on RAM word 0x10.
    op(32'h0000_0010, 32'h1122_3344, 4'hF, 1'b1);
    op(32'h0000_0010, 32'hAA00_0000, 4'h8, 1'b1);
    idle(32'h0000_0010, 1);
    check("ram_merge", dout, 32'hAA22_3344);
    idle(32'h0000_0012, 1);

    // LED byte write and be=0 no-op.
    op(32'hFFFF_0004, 32'h0000_00FF, 4'h1, 1'b1);
    op(32'hFFFF_0004, 32'h1234_5678, 4'h0, 1'b1);
    idle(32'hFFFF_0004, 2);

    // Unmapped write sets err; STATUS write clears it.
    op(32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    idle(32'h0001_0000, 1);
    op(32'hFFFF_000C, 32'h0000_0002, 4'h1, 1'b1);
    idle(32'hFFFF_000C, 1);
    op(32'h0000_1000, 32'h5555_5555, 4'hF, 1'b1);
    op(32'hFFFF_0000, 32'h0000_0007, 4'hF, 1'b1);
    idle(32'hFFFF_000C, 1);
    op(32'hFFFF_000C, 32'h0000_0002, 4'h1, 1'b1);

    // TOHOST halt, frozen CYCLE, ignored RAM write, then reset.
    op(32'hFFFF_0008, 32'h0000_0001, 4'hF, 1'b1);
    idle(32'hFFFF_0000, 3);
    op(32'h0000_0010, 32'h0BAD_F00D, 4'hF, 1'b1);
    op(32'hFFFF_000C, 32'h0000_0002, 4'h1, 1'b1);
    idle(32'h0000_0010, 1);
    do_reset();
    idle(32'hFFFF_0000, 2);

    // Fill a pool of RAM words so random reads have defined contents.
    for (int i = 0; i < 16; i++) op(i * 4, $urandom, 4'hF, 1'b1);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      if (k <= 4) begin
        a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      end else if (k <= 7) begin
        a = 32'hFFFF_0000 + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
        if (a[3:2] == 2'd2) d = 32'h0;
      end else if (k == 8) begin
        a = 32'h0001_0000 + $urandom_range(0, 255);
      end else begin
        a = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'hFFFF_0010;
      end
      op(a, d, b, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
